demux_8bits: RTL and testbench
==============================

DEMUX_8BITS -- requirements
Module: demux_8bits

Interface
REQ-001 Parameter DATA_W SHALL be: DATA_W, default 8, channel data width in bits.
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst SHALL be: rst  input  1  reset, synchronous, active-high.
REQ-004 Port in_valid SHALL be: in_valid  input  1  producer offers in_data this cycle.
REQ-005 Port in_ready SHALL be: in_ready  output  1  block accepts in_data this cycle.
REQ-006 Port in_data SHALL be: in_data  input  DATA_W  word to route.
REQ-007 Port sel SHALL be: sel  input  2  target channel index 0..3.
REQ-008 Port out_data SHALL be: out_data  output  4*DATA_W  channel k at bits [k*DATA_W+DATA_W-1 : k*DATA_W].
REQ-009 Port out_valid SHALL be: out_valid  output  4  bit k set means channel k holds an unconsumed word.
REQ-010 Port out_ack SHALL be: out_ack  input  4  bit k set means the consumer takes channel k this cycle.
REQ-011 Port xfer_cnt SHALL be: xfer_cnt  output  8  count of accepted input words, modulo 256.

Function
REQ-012 Target index t SHALL be sel, or the round-robin pointer when REQ-026 applies.
REQ-013 in_ready SHALL be combinational: in_ready = !out_valid[t] | out_ack[t].
REQ-014 An accept SHALL occur when in_valid && in_ready; in_valid without in_ready SHALL change nothing.
REQ-015 On accept, out_data[t] SHALL equal in_data and out_valid[t] SHALL be 1 from the next cycle (latency 1).
REQ-016 out_ack[k] with out_valid[k]=1 and no same-cycle load of k SHALL clear out_valid[k] next cycle.
REQ-017 Same-cycle ack and accept on channel t SHALL load the new word and keep out_valid[t]=1.
REQ-018 out_ack[k] with out_valid[k]=0 SHALL be ignored.
REQ-019 Acks on several channels in one cycle SHALL each take effect independently.
REQ-020 out_data[k] SHALL hold its last loaded value after ack; only an accept SHALL change it.
REQ-021 xfer_cnt SHALL increment by 1 per accept and wrap 255 -> 0.

Reset
REQ-022 With rst=1 at a clock edge, out_data, out_valid, xfer_cnt and the round-robin pointer SHALL become 0 at that edge.
REQ-023 rst SHALL take priority over a simultaneous accept or ack.
REQ-024 A word held in any channel when rst asserts SHALL be discarded.
REQ-025 in_ready SHALL be 1 in the first cycle after reset, since all channels are then empty.

Configuration
REQ-026 With macro DEMUX_RR_EN defined, sel SHALL be ignored and t SHALL come from a 2-bit pointer.
REQ-027 The pointer SHALL advance 0->1->2->3->0 on each accept only, and hold otherwise.
REQ-028 Without DEMUX_RR_EN, t SHALL equal sel and no pointer SHALL exist.
REQ-029 The port list SHALL be identical with and without DEMUX_RR_EN.

Structure
REQ-030 A shared package demux_pkg SHALL hold the NUM_CH=4 and SEL_W=2 constants and the channel-index typedef.
REQ-031 One sub-module, demux_chan_reg, SHALL implement a single channel's data register and valid flag, instantiated 4 times.
REQ-032 Target decode, in_ready and xfer_cnt logic SHALL reside in the top level.

Verification
REQ-033 Scenario: reset, then sel=2, in_data=0xA5, in_valid=1 for 1 cycle -> next cycle out_valid=4'b0100, channel 2 data=0xA5, xfer_cnt=1.
REQ-034 Scenario: channel 1 full, sel=1, in_valid=1, out_ack=0 -> in_ready=0, channel 1 data unchanged, xfer_cnt unchanged.
REQ-035 Scenario: channel 1 full with 0x11, sel=1, in_data=0x22, out_ack[1]=1 same cycle -> accepted; next cycle channel 1=0x22, out_valid[1]=1.
REQ-036 Scenario: 256 accepts with acks between them -> xfer_cnt returns to 0.
REQ-037 Scenario: DEMUX_RR_EN defined, sel held at 3, words 0x10..0x14 accepted -> they land on channels 0,1,2,3,0.
REQ-038 Scenario: rst asserted while out_valid=4'b1111 and in_valid=1 -> next cycle out_valid=0, xfer_cnt=0, pointer=0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and channel-index type for the 1-to-4 registered demux.
package demux_pkg;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef logic [SEL_W-1:0] chan_idx_t;
endpackage

// File: rtl/demux_chan_reg.sv
// One output channel: data register plus valid flag with load/ack handshake.
module demux_chan_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              ack,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      // a load wins over a same-cycle ack, so the channel stays full
      dout  <= din;
      valid <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_8bits.sv
// Registered 1-to-4 demux with ready/valid input and per-channel ack.
// Optional macro DEMUX_RR_EN: ignore sel and route round-robin via a 2-bit pointer.
module demux_8bits
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         sel,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ack,
  output logic [7:0]               xfer_cnt
);

  chan_idx_t          tgt;
  logic               accept;
  logic [NUM_CH-1:0]  load;

`ifdef DEMUX_RR_EN
  chan_idx_t rr_ptr;

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (accept)
      rr_ptr <= rr_ptr + SEL_W'(1);
  end

  assign tgt = rr_ptr;
`else
  assign tgt = sel;
`endif

  assign in_ready = !out_valid[tgt] || out_ack[tgt];
  assign accept   = in_valid && in_ready;

  always_comb begin
    load      = '0;
    load[tgt] = accept;
  end

  always_ff @(posedge clk) begin
    if (rst)
      xfer_cnt <= '0;
    else if (accept)
      xfer_cnt <= xfer_cnt + 8'd1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux_chan_reg #(
      .DATA_W(DATA_W)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .load (load[k]),
      .ack  (out_ack[k]),
      .din  (in_data),
      .dout (out_data[k*DATA_W +: DATA_W]),
      .valid(out_valid[k])
    );
  end

endmodule

// File: tb/tb_demux_8bits.sv
// Directed self-checking bench for demux_8bits (both sel and DEMUX_RR_EN builds).
module tb_demux_8bits;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  sel;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ack;
  logic [7:0]  xfer_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  exp_cnt;

  always #5 clk = ~clk;

  demux_8bits #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .sel      (sel),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ack  (out_ack),
    .xfer_cnt (xfer_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ch(input int k);
    return out_data[k*8 +: 8];
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ack = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; sel = '0; out_ack = '0;
    step();
    do_reset();
    check("rst_valid", out_valid, 4'b0000);
    check("rst_data",  out_data, 32'h0);
    check("rst_cnt",   xfer_cnt, 8'd0);
    check("rst_ready", in_ready, 1'b1);

`ifdef DEMUX_RR_EN
    sel = 2'd3;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h10 + 8'(i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("rr_valid4", out_valid, 4'b1111);
    check("rr_ch0", ch(0), 8'h10);
    check("rr_ch1", ch(1), 8'h11);
    check("rr_ch2", ch(2), 8'h12);
    check("rr_ch3", ch(3), 8'h13);
    // pointer is back on ch0 which is full: stall must not move it
    in_data = 8'h99; in_valid = 1'b1; #1;
    check("rr_stall_ready", in_ready, 1'b0);
    step();
    check("rr_stall_cnt", xfer_cnt, 8'd4);
    check("rr_stall_ch0", ch(0), 8'h10);
    in_data = 8'h14; out_ack = 4'b0001; #1;
    check("rr_wrap_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0; out_ack = '0;
    check("rr_wrap_ch0", ch(0), 8'h14);
    check("rr_wrap_ch1", ch(1), 8'h11);
    check("rr_wrap_valid", out_valid, 4'b1111);
    check("rr_wrap_cnt", xfer_cnt, 8'd5);
    // reset with pending accept: pointer must restart at 0, not 1
    rst = 1'b1; in_valid = 1'b1; out_ack = 4'b1111;
    step();
    rst = 1'b0; out_ack = '0;
    check("rr_rst_valid", out_valid, 4'b0000);
    check("rr_rst_cnt", xfer_cnt, 8'd0);
    in_data = 8'h55; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("rr_rst_ptr", out_valid, 4'b0001);
    check("rr_rst_ch0", ch(0), 8'h55);
`else
    sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("a5_valid", out_valid, 4'b0100);
    check("a5_ch2", ch(2), 8'hA5);
    check("a5_cnt", xfer_cnt, 8'd1);

    sel = 2'd1; in_data = 8'h11; in_valid = 1'b1;
    step();
    check("ch1_fill_valid", out_valid, 4'b0110);

    in_data = 8'h33; #1;
    check("full_ready", in_ready, 1'b0);
    step();
    check("full_ch1", ch(1), 8'h11);
    check("full_cnt", xfer_cnt, 8'd2);

    in_data = 8'h22; out_ack = 4'b0010; #1;
    check("ackload_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0; out_ack = '0;
    check("ackload_ch1", ch(1), 8'h22);
    check("ackload_valid", out_valid, 4'b0110);
    check("ackload_cnt", xfer_cnt, 8'd3);

    // ack on empty ch0 ignored, ch1/ch2 cleared together, data retained
    out_ack = 4'b0111;
    step();
    out_ack = '0;
    check("multiack_valid", out_valid, 4'b0000);
    check("multiack_ch1", ch(1), 8'h22);
    check("multiack_ch2", ch(2), 8'hA5);

    do_reset();
    exp_cnt = 8'd0;
    for (int i = 0; i < 256; i++) begin
      sel = 2'(i); in_data = 8'(i); in_valid = 1'b1; out_ack = '0;
      step();
      exp_cnt = exp_cnt + 8'd1;
      check("loop_cnt", xfer_cnt, exp_cnt);
      in_valid = 1'b0; out_ack = 4'b0001 << sel;
      step();
    end
    out_ack = '0;
    check("wrap_cnt", xfer_cnt, 8'd0);
    check("wrap_valid", out_valid, 4'b0000);
    check("wrap_ch0", ch(0), 8'd252);
    check("wrap_ch3", ch(3), 8'd255);

    for (int k = 0; k < 4; k++) begin
      sel = 2'(k); in_data = 8'hC0 + 8'(k); in_valid = 1'b1;
      step();
    end
    check("fill_valid", out_valid, 4'b1111);
    check("fill_cnt", xfer_cnt, 8'd4);
    sel = 2'd0; out_ack = 4'b1111; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ack = '0;
    check("rst2_valid", out_valid, 4'b0000);
    check("rst2_cnt", xfer_cnt, 8'd0);
    check("rst2_data", out_data, 32'h0);
    check("rst2_ready", in_ready, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
